// File: rtl/lfsr_checker_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lfsr_checker_pkg
//  Purpose  : Shared PRBS definitions for the LFSR generator/checker pair:
//             register width, feedback taps (x^8+x^6+x^5+x^4+1), generator
//             seed, checker state encoding and the tap-parity predictor.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package lfsr_checker_pkg;

   localparam int unsigned        LFSR_W    = 8;
   // Taps on bits 7,5,4,3 of a shift-left register feeding bit 0.
   localparam logic [LFSR_W-1:0]  LFSR_TAPS = 8'hB8;
   localparam logic [LFSR_W-1:0]  LFSR_SEED = 8'h01;

   typedef enum logic [0:0] {
      ST_SEARCH = 1'b0,
      ST_LOCKED = 1'b1
   } chk_state_e;

   // Next bit the generator will insert, given its last LFSR_W outputs.
   function automatic logic lfsr_pred(input logic [LFSR_W-1:0] hist);
      return ^(hist & LFSR_TAPS);
   endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr_checker.sv
`default_nettype none
// ============================================================================
//  Module   : lfsr_checker
//  Purpose  : Receive-side PRBS checker. Self-synchronises to the 8-bit LFSR
//             sequence, then counts bit errors and declares loss of sync when
//             too many mismatches fall inside one monitoring window.
//  Ports    : clk        - rising-edge clock
//             rst        - asynchronous active-high reset
//             bit_valid  - bit_in is sampled when high
//             bit_in     - received PRBS bit
//             clr_err    - synchronous clear of err_cnt
//             locked     - high while in LOCKED state
//             err_pulse  - one-cycle pulse per mismatch while LOCKED
//             sync_loss  - one-cycle pulse on LOCKED->SEARCH
//             err_cnt    - saturating count of LOCKED mismatches
//  Revision : 1.0 - initial release
// ============================================================================
module lfsr_checker
   import lfsr_checker_pkg::*;
#(
   parameter int unsigned LOCK_CNT   = 16,
   parameter int unsigned WIN_LEN    = 64,
   parameter int unsigned ERR_THRESH = 4,
   parameter int unsigned ERR_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             bit_valid,
   input  logic             bit_in,
   input  logic             clr_err,
   output logic             locked,
   output logic             err_pulse,
   output logic             sync_loss,
   output logic [ERR_W-1:0] err_cnt
);

   localparam int unsigned FILL_W  = $clog2(LFSR_W + 1);
   localparam int unsigned MATCH_W = $clog2(LOCK_CNT + 1);
   localparam int unsigned WIN_W   = $clog2(WIN_LEN + 1);
   localparam int unsigned WERR_W  = $clog2(ERR_THRESH + 1);

   chk_state_e         state_q,     state_d;
   logic [LFSR_W-1:0]  hist_q,      hist_d;
   logic [FILL_W-1:0]  fill_q,      fill_d;
   logic [MATCH_W-1:0] match_q,     match_d;
   logic [WIN_W-1:0]   win_cnt_q,   win_cnt_d;
   logic [WERR_W-1:0]  win_err_q,   win_err_d;
   logic [ERR_W-1:0]   err_cnt_q,   err_cnt_d;
   logic               locked_q,    locked_d;
   logic               err_pulse_q, err_pulse_d;
   logic               sync_loss_q, sync_loss_d;

   logic               w_pred;
   logic               w_mis;

   assign w_pred = lfsr_pred(hist_q);
   assign w_mis  = bit_in ^ w_pred;

   always_comb begin
      state_d     = state_q;
      hist_d      = hist_q;
      fill_d      = fill_q;
      match_d     = match_q;
      win_cnt_d   = win_cnt_q;
      win_err_d   = win_err_q;
      err_cnt_d   = err_cnt_q;
      locked_d    = locked_q;
      err_pulse_d = 1'b0;
      sync_loss_d = 1'b0;

      if (bit_valid) begin
         case (state_q)
            ST_SEARCH: begin
               hist_d = {hist_q[LFSR_W-2:0], bit_in};
               if (fill_q != FILL_W'(LFSR_W)) begin
                  // History not yet full: nothing meaningful to compare.
                  fill_d = fill_q + 1'b1;
               end else if (!w_mis && (hist_q != '0)) begin
                  // All-zero history predicts zeros forever; never lock on it.
                  if (match_q == MATCH_W'(LOCK_CNT - 1)) begin
                     state_d   = ST_LOCKED;
                     locked_d  = 1'b1;
                     match_d   = '0;
                     win_cnt_d = '0;
                     win_err_d = '0;
                  end else begin
                     match_d = match_q + 1'b1;
                  end
               end else begin
                  match_d = '0;
               end
            end

            ST_LOCKED: begin
               // Free-running local reference: a single corrupt input bit
               // cannot pollute the history and cause follow-on mismatches.
               hist_d      = {hist_q[LFSR_W-2:0], w_pred};
               err_pulse_d = w_mis;
               if (w_mis && (err_cnt_q != '1)) begin
                  err_cnt_d = err_cnt_q + 1'b1;
               end

               if (w_mis && (win_err_q == WERR_W'(ERR_THRESH - 1))) begin
                  // Loss of sync outranks the window wrap on the same bit.
                  state_d     = ST_SEARCH;
                  locked_d    = 1'b0;
                  sync_loss_d = 1'b1;
                  fill_d      = '0;
                  match_d     = '0;
                  win_cnt_d   = '0;
                  win_err_d   = '0;
               end else if (win_cnt_q == WIN_W'(WIN_LEN - 1)) begin
                  win_cnt_d = '0;
                  win_err_d = '0;
               end else begin
                  win_cnt_d = win_cnt_q + 1'b1;
                  if (w_mis) begin
                     win_err_d = win_err_q + 1'b1;
                  end
               end
            end

            default: begin
               state_d = ST_SEARCH;
            end
         endcase
      end

      // Clear wins over a same-cycle mismatch; that error is not counted.
      if (clr_err) begin
         err_cnt_d = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_SEARCH;
         hist_q      <= '0;
         fill_q      <= '0;
         match_q     <= '0;
         win_cnt_q   <= '0;
         win_err_q   <= '0;
         err_cnt_q   <= '0;
         locked_q    <= 1'b0;
         err_pulse_q <= 1'b0;
         sync_loss_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         hist_q      <= hist_d;
         fill_q      <= fill_d;
         match_q     <= match_d;
         win_cnt_q   <= win_cnt_d;
         win_err_q   <= win_err_d;
         err_cnt_q   <= err_cnt_d;
         locked_q    <= locked_d;
         err_pulse_q <= err_pulse_d;
         sync_loss_q <= sync_loss_d;
      end
   end

   assign locked    = locked_q;
   assign err_pulse = err_pulse_q;
   assign sync_loss = sync_loss_q;
   assign err_cnt   = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_checker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lfsr_checker
//  Purpose  : Self-checking bench for lfsr_checker. A reference generator
//             drives the stream; a bit-level behavioural model predicts every
//             output each cycle, and directed checks pin down lock latency,
//             error counting, loss of sync, clear priority and reset.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lfsr_checker;

   logic        clk = 1'b0;
   logic        rst;
   logic        bit_valid;
   logic        bit_in;
   logic        clr_err;
   logic        locked;
   logic        err_pulse;
   logic        sync_loss;
   logic [15:0] err_cnt;

   always #5 clk = ~clk;

   lfsr_checker #(
      .LOCK_CNT   (16),
      .WIN_LEN    (64),
      .ERR_THRESH (4),
      .ERR_W      (16)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .bit_valid (bit_valid),
      .bit_in    (bit_in),
      .clr_err   (clr_err),
      .locked    (locked),
      .err_pulse (err_pulse),
      .sync_loss (sync_loss),
      .err_cnt   (err_cnt)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int n_pulse = 0;
   int n_loss  = 0;

   // Stream source: x^8+x^6+x^5+x^4+1, shift left, new bit into bit 0.
   logic [7:0] gen;

   // Behavioural model state.
   bit         m_locked, m_pulse, m_loss;
   logic [7:0] m_ref;      // last 8 bits received (search) / local reference (locked)
   int         m_seen;     // valid bits since entering search, capped at 8
   int         m_run;      // consecutive matches after the fill
   int         m_wpos;     // position in the current error window
   int         m_werr;     // errors in the current window
   longint     m_err;      // total counted errors (unsaturated)

   function automatic bit feedback(input logic [7:0] s);
      return s[7] ^ s[5] ^ s[4] ^ s[3];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_tests++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic model_reset();
      m_locked = 0; m_pulse = 0; m_loss = 0;
      m_ref = 8'h00; m_seen = 0; m_run = 0; m_wpos = 0; m_werr = 0; m_err = 0;
   endtask

   task automatic model(input bit v, input bit b, input bit clr);
      bit expb, mis, was_zero;
      m_pulse = 0;
      m_loss  = 0;
      if (v) begin
         expb = feedback(m_ref);
         mis  = (b != expb);
         if (!m_locked) begin
            was_zero = (m_ref == 8'h00);
            m_ref    = {m_ref[6:0], b};
            if (m_seen < 8) m_seen++;
            else if (!mis && !was_zero) begin
               m_run++;
               if (m_run == 16) begin
                  m_locked = 1; m_run = 0; m_wpos = 0; m_werr = 0;
               end
            end else m_run = 0;
         end else begin
            m_ref = {m_ref[6:0], expb};
            if (mis) begin
               m_pulse = 1; m_err++; m_werr++;
            end
            if (mis && m_werr == 4) begin
               m_locked = 0; m_loss = 1; m_seen = 0; m_run = 0; m_wpos = 0; m_werr = 0;
            end else begin
               m_wpos++;
               if (m_wpos == 64) begin
                  m_wpos = 0; m_werr = 0;
               end
            end
         end
      end
      if (clr) m_err = 0;
   endtask

   // One clock: drive, let the edge happen, update model, compare #1 later.
   task automatic step(input bit v, input bit b, input bit clr);
      longint e;
      bit_valid = v;
      bit_in    = b;
      clr_err   = clr;
      @(posedge clk);
      model(v, b, clr);
      #1;
      e = (m_err > 65535) ? 65535 : m_err;
      chk("locked",    {31'd0, locked},    {31'd0, m_locked});
      chk("err_pulse", {31'd0, err_pulse}, {31'd0, m_pulse});
      chk("sync_loss", {31'd0, sync_loss}, {31'd0, m_loss});
      chk("err_cnt",   {16'd0, err_cnt},   32'(e));
      if (err_pulse === 1'b1) n_pulse++;
      if (sync_loss === 1'b1) n_loss++;
   endtask

   // Send one bit; when valid the generator advances and 'e' corrupts it.
   task automatic send(input bit v, input bit e, input bit clr);
      bit b;
      if (v) begin
         gen = {gen[6:0], feedback(gen)};
         b   = gen[0] ^ e;
      end else begin
         b = 1'($urandom_range(0, 1));
      end
      step(v, b, clr);
   endtask

   task automatic run_until_lock(input bit toggle, output int nbits, output int ncyc);
      bit v;
      nbits = 0;
      ncyc  = -1;
      for (int c = 0; c < 400; c++) begin
         v = toggle ? (c % 2 == 0) : 1'b1;
         send(v, 1'b0, 1'b0);
         if (v) nbits++;
         if (locked === 1'b1) begin
            ncyc = c + 1;
            break;
         end
      end
   endtask

   // Asynchronous reset applied between edges; outputs must clear at once.
   task automatic do_reset();
      rst       = 1'b1;
      bit_valid = 1'b0;
      clr_err   = 1'b0;
      #1;
      chk("rst_locked",    {31'd0, locked},    32'd0);
      chk("rst_err_pulse", {31'd0, err_pulse}, 32'd0);
      chk("rst_sync_loss", {31'd0, sync_loss}, 32'd0);
      chk("rst_err_cnt",   {16'd0, err_cnt},   32'd0);
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      int nbits, ncyc, ninj, p0, l0, maxlock;
      bit e;

      rst = 1'b1; bit_valid = 1'b0; bit_in = 1'b0; clr_err = 1'b0;
      model_reset();
      gen = 8'h01;
      repeat (2) @(posedge clk);
      #1;
      chk("init_locked",  {31'd0, locked},  32'd0);
      chk("init_err_cnt", {16'd0, err_cnt}, 32'd0);
      rst = 1'b0;

      // 1: clean stream locks after 24 valid bits, no errors over 1000 bits.
      run_until_lock(1'b0, nbits, ncyc);
      chk("t1_lock_bits", 32'(nbits), 32'd24);
      for (int i = 0; i < 1000; i++) send(1'b1, 1'b0, 1'b0);
      chk("t1_err_cnt", {16'd0, err_cnt}, 32'd0);
      chk("t1_locked",  {31'd0, locked},  32'd1);

      // 2: one corrupt bit -> exactly one pulse, lock held.
      p0 = n_pulse;
      send(1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 10; i++) send(1'b1, 1'b0, 1'b0);
      chk("t2_pulses",  32'(n_pulse - p0), 32'd1);
      chk("t2_err_cnt", {16'd0, err_cnt},  32'd1);
      chk("t2_locked",  {31'd0, locked},   32'd1);

      // 3: dense errors until sync is lost, then relock on a clean stream.
      l0 = n_loss;
      ninj = 0;
      for (int i = 0; i < 20 && n_loss == l0; i++) begin
         e = (i % 2 == 0);
         if (e) ninj++;
         send(1'b1, e, 1'b0);
      end
      chk("t3_loss",    32'(n_loss - l0), 32'd1);
      chk("t3_unlock",  {31'd0, locked},  32'd0);
      run_until_lock(1'b0, nbits, ncyc);
      chk("t3_relock_bits", 32'(nbits), 32'd24);
      chk("t3_err_cnt", {16'd0, err_cnt}, 32'(1 + ninj));

      // 4: constant zeros never lock.
      do_reset();
      maxlock = 0;
      for (int i = 0; i < 200; i++) begin
         step(1'b1, 1'b0, 1'b0);
         if (locked === 1'b1) maxlock = 1;
      end
      chk("t4_never_locked", 32'(maxlock), 32'd0);

      // 5: valid toggling; clear wins over same-cycle mismatch.
      do_reset();
      gen = 8'h01;
      run_until_lock(1'b1, nbits, ncyc);
      chk("t5_lock_bits",   32'(nbits), 32'd24);
      chk("t5_lock_cycles", 32'(ncyc),  32'd47);
      send(1'b1, 1'b1, 1'b0);
      send(1'b0, 1'b0, 1'b0);
      chk("t5_err_one", {16'd0, err_cnt}, 32'd1);
      send(1'b1, 1'b1, 1'b1);
      chk("t5_clr_cnt",   {16'd0, err_cnt},   32'd0);
      chk("t5_clr_pulse", {31'd0, err_pulse}, 32'd1);

      // 6: 3 errors in each of two windows -> no loss; then mid-stream reset.
      do_reset();
      gen = 8'h01;
      run_until_lock(1'b0, nbits, ncyc);
      l0 = n_loss;
      for (int k = 0; k < 128; k++) begin
         e = (k == 10 || k == 20 || k == 30 || k == 70 || k == 80 || k == 90);
         send(1'b1, e, 1'b0);
      end
      chk("t6_no_loss", 32'(n_loss - l0), 32'd0);
      chk("t6_locked",  {31'd0, locked},  32'd1);
      chk("t6_err_cnt", {16'd0, err_cnt}, 32'd6);
      do_reset();
      run_until_lock(1'b0, nbits, ncyc);
      chk("t6_relock_bits", 32'(nbits), 32'd24);

      // Random traffic: sparse valid gaps, occasional errors and clears.
      for (int i = 0; i < 3000; i++) begin
         send(($urandom % 4) != 0, ($urandom % 48) == 0, ($urandom % 256) == 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
